// File: rtl/vx_mem_arb_pkg.sv
// Shared helpers for the L1 memory arbiter: requester-index width and widened tag width.
package vx_mem_arb_pkg;

  function automatic int log_reqs(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int tag_out_width(input int num_reqs, input int tag_in_width);
    return tag_in_width + log_reqs(num_reqs);
  endfunction

endpackage

// File: rtl/vx_mem_skid_buf.sv
// 2-entry elastic buffer for a packed memory request, 1-cycle latency.
// full depends only on the entry count, so the upstream ready has no path from out_ready.
module vx_mem_skid_buf #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready,
  output logic full
);

  T           slots [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign full      = (count == 2'd2);
  assign in_ready  = ~full;
  assign out_valid = (count != 2'd0);
  assign out_data  = slots[rd_ptr];
  assign push      = in_valid & ~full;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The head slot is never overwritten while it is presented, so the output holds under backpressure.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/vx_l1_mem_arbiter.sv
// Round-robin share of one L1 memory port among NUM_REQS caches; requests take 1 cycle through
// a 2-entry skid buffer, reads are capped at MAX_PENDING, responses route back combinationally.
module vx_l1_mem_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter  int NUM_REQS      = 2,
  parameter  int DATA_WIDTH    = 512,
  parameter  int ADDR_WIDTH    = 26,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int MAX_PENDING   = 16,
  localparam int LOG_REQS      = log_reqs(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width(NUM_REQS, TAG_IN_WIDTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_in_valid,
  input  logic [NUM_REQS-1:0]                req_in_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0]   req_in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_in_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_in_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   req_in_tag,
  output logic [NUM_REQS-1:0]                req_in_ready,
  output logic [NUM_REQS-1:0]                rsp_out_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]     rsp_out_data,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]   rsp_out_tag,
  input  logic [NUM_REQS-1:0]                rsp_out_ready,
  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]            mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic [DATA_WIDTH-1:0]              mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]           mem_req_tag,
  input  logic                               mem_req_ready,
  input  logic                               mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]           mem_rsp_tag,
  output logic                               mem_rsp_ready,
  output logic                               busy
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int PEND_WIDTH = $clog2(MAX_PENDING + 1);

  typedef logic [LOG_REQS-1:0] idx_t;

  // Request struct lives here because its field widths follow this instance's parameters.
  typedef struct packed {
    logic                     rw;
    logic [BE_WIDTH-1:0]      byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } mem_req_t;

  idx_t                  ptr;
  idx_t                  gidx;
  logic                  grant_vld;
  logic                  accept;
  logic                  acc_rd;
  logic                  rd_block;
  logic                  buf_full;
  logic                  buf_in_ready;
  logic [PEND_WIDTH-1:0] pending;
  mem_req_t              buf_in;
  mem_req_t              buf_out;
  idx_t                  rsp_idx;
  logic                  rsp_hit;
  logic                  rsp_fire;

  // Scan from ptr upward; iterating downward lets the nearest valid requester win.
  always_comb begin
    grant_vld = 1'b0;
    gidx      = ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (req_in_valid[(int'(ptr) + k) % NUM_REQS]) begin
        grant_vld = 1'b1;
        gidx      = idx_t'((int'(ptr) + k) % NUM_REQS);
      end
    end
  end

  assign rd_block = (pending == PEND_WIDTH'(MAX_PENDING));

  always_comb begin
    req_in_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_in_ready[i] = grant_vld && (gidx == idx_t'(i)) && !buf_full
                        && !(rd_block && !req_in_rw[i]);
    end
  end

  assign accept = grant_vld & buf_in_ready & ~(rd_block & ~req_in_rw[gidx]);
  assign acc_rd = accept & ~req_in_rw[gidx];

  always_comb begin
    buf_in.rw     = req_in_rw[gidx];
    buf_in.byteen = req_in_byteen[gidx*BE_WIDTH +: BE_WIDTH];
    buf_in.addr   = req_in_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    buf_in.data   = req_in_data[gidx*DATA_WIDTH +: DATA_WIDTH];
    buf_in.tag    = {req_in_tag[gidx*TAG_IN_WIDTH +: TAG_IN_WIDTH], gidx};
  end

  vx_mem_skid_buf #(.T(mem_req_t)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   (buf_in),
    .in_ready  (buf_in_ready),
    .out_valid (mem_req_valid),
    .out_data  (buf_out),
    .out_ready (mem_req_ready),
    .full      (buf_full)
  );

  assign mem_req_rw     = buf_out.rw;
  assign mem_req_byteen = buf_out.byteen;
  assign mem_req_addr   = buf_out.addr;
  assign mem_req_data   = buf_out.data;
  assign mem_req_tag    = buf_out.tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      pending <= '0;
    end else begin
      if (accept) ptr <= idx_t'((int'(gidx) + 1) % NUM_REQS);
      if (acc_rd && !rsp_fire)      pending <= pending + PEND_WIDTH'(1);
      else if (!acc_rd && rsp_fire) pending <= pending - PEND_WIDTH'(1);
    end
  end

  assign rsp_idx  = mem_rsp_tag[LOG_REQS-1:0];
  assign rsp_hit  = (int'(rsp_idx) < NUM_REQS);
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

  // Unroutable responses are swallowed so the memory side can never wedge on them.
  always_comb begin
    rsp_out_valid = '0;
    mem_rsp_ready = 1'b1;
    if (rsp_hit) begin
      rsp_out_valid[rsp_idx] = mem_rsp_valid;
      mem_rsp_ready          = rsp_out_ready[rsp_idx];
    end
  end

  assign rsp_out_data = {NUM_REQS{mem_rsp_data}};
  assign rsp_out_tag  = {NUM_REQS{mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS]}};

  assign busy = mem_req_valid | (pending != '0);

  always_ff @(posedge clk) begin
    if (reset && mem_rsp_valid) begin
      assert (rsp_hit) else $error("vx_l1_mem_arbiter: response index %0d out of range", rsp_idx);
    end
  end

endmodule
